// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: serve, fall, bounce and miss sequencing for a single ball,
// with clamped horizontal steering. All outputs are registered and advance on frame ticks.
module ball_motion_ctrl #(
  parameter int X_MIN       = 84,
  parameter int X_MAX       = 596,
  parameter int X_INIT      = 340,
  parameter int Y_BOTTOM    = 479,
  parameter int X_STEP      = 4,
  parameter int VY_INIT     = 1,
  parameter int VY_MAX      = 8,
  parameter int RISE_FRAMES = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       left,
  input  logic       right,
  input  logic       on_platform,
  output logic [9:0] x_ball,
  output logic [8:0] y_ball,
  output logic [1:0] state,
  output logic       miss,
  output logic [7:0] score,
  output logic [3:0] vy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int CW = $clog2(RISE_FRAMES + 1);

  localparam logic [9:0]    X_INIT_L   = 10'(X_INIT);
  localparam logic [9:0]    X_MIN_L    = 10'(X_MIN);
  localparam logic [9:0]    X_MAX_L    = 10'(X_MAX);
  localparam logic [9:0]    X_STEP_L   = 10'(X_STEP);
  localparam logic [10:0]   X_LEFT_LIM = 11'(X_MIN + X_STEP);
  localparam logic [10:0]   X_MAX_W    = 11'(X_MAX);
  localparam logic [9:0]    Y_BOTTOM_W = 10'(Y_BOTTOM);
  localparam logic [8:0]    Y_BOTTOM_L = 9'(Y_BOTTOM);
  localparam logic [3:0]    VY_INIT_L  = 4'(VY_INIT);
  localparam logic [3:0]    VY_MAX_L   = 4'(VY_MAX);
  localparam logic [CW-1:0] RISE_LOAD  = CW'(RISE_FRAMES);

  state_t        st_q, st_d;
  logic [9:0]    x_d;
  logic [8:0]    y_d;
  logic [7:0]    score_d;
  logic [3:0]    vy_d;
  logic          miss_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          active;
  logic [10:0]   x_sum;
  logic [9:0]    x_move;
  logic [9:0]    y_sum;
  logic [8:0]    y_dec;
  logic [CW-1:0] cnt_dec;
  logic [7:0]    score_inc;

  assign state     = st_q;
  assign active    = frame_tick && !pause;
  assign x_sum     = {1'b0, x_ball} + {1'b0, X_STEP_L};
  assign y_sum     = {1'b0, y_ball} + {6'd0, vy};
  assign y_dec     = ({5'd0, vy} < y_ball) ? (y_ball - {5'd0, vy}) : 9'd0;
  assign cnt_dec   = (cnt_q != '0) ? (cnt_q - CW'(1)) : '0;
  assign score_inc = score + 8'd1;

  // Horizontal step with clamping; the left bound is checked before subtracting so it can't wrap.
  always_comb begin
    x_move = x_ball;
    if (left && !right) begin
      x_move = ({1'b0, x_ball} >= X_LEFT_LIM) ? (x_ball - X_STEP_L) : X_MIN_L;
    end else if (right && !left) begin
      x_move = (x_sum <= X_MAX_W) ? x_sum[9:0] : X_MAX_L;
    end
  end

  always_comb begin
    st_d    = st_q;
    x_d     = x_ball;
    y_d     = y_ball;
    score_d = score;
    vy_d    = vy;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    case (st_q)
      IDLE: begin
        x_d  = X_INIT_L;
        y_d  = 9'd0;
        vy_d = VY_INIT_L;
        if (start && !pause) begin
          st_d    = FALL;
          score_d = 8'd0;
        end
      end
      FALL: begin
        if (active) begin
          x_d = x_move;
          // A platform hit wins over a bottom crossing on the same tick.
          if (on_platform) begin
            st_d  = RISE;
            cnt_d = RISE_LOAD;
            if (score != 8'hFF) begin
              score_d = score_inc;
              if (score_inc[1:0] == 2'b00 && vy < VY_MAX_L) begin
                vy_d = vy + 4'd1;
              end
            end
          end else if (y_sum >= Y_BOTTOM_W) begin
            y_d    = Y_BOTTOM_L;
            st_d   = OVER;
            miss_d = 1'b1;
          end else begin
            y_d = y_sum[8:0];
          end
        end
      end
      RISE: begin
        if (active) begin
          x_d   = x_move;
          y_d   = y_dec;
          cnt_d = cnt_dec;
          if (cnt_dec == '0 || y_dec == 9'd0) begin
            st_d = FALL;
          end
        end
      end
      OVER: begin
        if (start && !pause) begin
          st_d = IDLE;
          x_d  = X_INIT_L;
          y_d  = 9'd0;
          vy_d = VY_INIT_L;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      x_ball <= X_INIT_L;
      y_ball <= 9'd0;
      score  <= 8'd0;
      vy     <= VY_INIT_L;
      miss   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      x_ball <= x_d;
      y_ball <= y_d;
      score  <= score_d;
      vy     <= vy_d;
      miss   <= miss_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: a vector table for basic motion plus
// hand-written sequences for bottom miss, clamping, bounce scoring, pause and reset.
module tb_ball_motion_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       left;
  logic       right;
  logic       on_platform;
  logic [9:0] x_ball;
  logic [8:0] y_ball;
  logic [1:0] state;
  logic       miss;
  logic [7:0] score;
  logic [3:0] vy;

  int checks   = 0;
  int failures = 0;

  localparam int S_IDLE = 0;
  localparam int S_FALL = 1;
  localparam int S_RISE = 2;
  localparam int S_OVER = 3;

  typedef struct {
    int ft;
    int st;
    int pa;
    int l;
    int r;
    int op;
    int e_state;
    int e_x;
    int e_y;
    int e_score;
    int e_vy;
    int e_miss;
  } vec_t;

  vec_t vecs[16];

  ball_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .pause       (pause),
    .left        (left),
    .right       (right),
    .on_platform (on_platform),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .state       (state),
    .miss        (miss),
    .score       (score),
    .vy          (vy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1ns after a rising edge, outputs are sampled there too.
  task automatic step(input int ft, input int st, input int pa, input int l, input int r,
                      input int op);
    frame_tick  = (ft != 0);
    start       = (st != 0);
    pause       = (pa != 0);
    left        = (l != 0);
    right       = (r != 0);
    on_platform = (op != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input int l, input int r);
    for (int i = 0; i < n; i++) step(1, 0, 0, l, r, 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int e_state, input int e_x, input int e_y,
                         input int e_score, input int e_vy, input int e_miss);
    chk({name, ".state"}, int'(state), e_state);
    chk({name, ".x"}, int'(x_ball), e_x);
    chk({name, ".y"}, int'(y_ball), e_y);
    chk({name, ".score"}, int'(score), e_score);
    chk({name, ".vy"}, int'(vy), e_vy);
    chk({name, ".miss"}, int'(miss), e_miss);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic serve();
    step(0, 1, 0, 0, 0, 0);
    chk("serve.state", int'(state), S_FALL);
  endtask

  // Platform hit while falling, then rise until back in FALL (bounded wait).
  task automatic bounce();
    int n;
    n = 0;
    step(1, 0, 0, 0, 0, 1);
    while (state != 2'd1 && n < 30) begin
      step(1, 0, 0, 0, 0, 0);
      n++;
    end
    chk("bounce_return", int'(state), S_FALL);
  endtask

  initial begin
    reset       = 1'b0;
    frame_tick  = 1'b0;
    start       = 1'b0;
    pause       = 1'b0;
    left        = 1'b0;
    right       = 1'b0;
    on_platform = 1'b0;

    //           ft st pa  l  r op  state   x    y  sc vy miss
    vecs[0]  = '{0, 0, 0, 0, 0, 0, S_IDLE, 340, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, S_IDLE, 340, 0, 0, 1, 0};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, S_IDLE, 340, 0, 0, 1, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, S_FALL, 340, 0, 0, 1, 0};
    vecs[4]  = '{1, 0, 0, 0, 1, 0, S_FALL, 344, 1, 0, 1, 0};
    vecs[5]  = '{1, 0, 0, 1, 0, 0, S_FALL, 340, 2, 0, 1, 0};
    vecs[6]  = '{1, 0, 0, 1, 1, 0, S_FALL, 340, 3, 0, 1, 0};
    vecs[7]  = '{1, 0, 1, 1, 0, 0, S_FALL, 340, 3, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, S_FALL, 340, 3, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, S_FALL, 340, 3, 0, 1, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 1, S_RISE, 340, 3, 1, 1, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 0, S_RISE, 340, 2, 1, 1, 0};
    vecs[12] = '{1, 0, 0, 0, 1, 0, S_RISE, 344, 1, 1, 1, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 0, S_FALL, 344, 0, 1, 1, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0, S_FALL, 344, 1, 1, 1, 0};
    vecs[15] = '{1, 0, 0, 0, 0, 0, S_FALL, 344, 2, 1, 1, 0};

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_all("reset", S_IDLE, 340, 0, 0, 1, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk_all("post_reset_idle", S_IDLE, 340, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ft, vecs[i].st, vecs[i].pa, vecs[i].l, vecs[i].r, vecs[i].op);
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_x, vecs[i].e_y,
              vecs[i].e_score, vecs[i].e_vy, vecs[i].e_miss);
    end

    // Serve and fall ten ticks
    do_reset();
    serve();
    ticks(10, 0, 0);
    chk_all("fall10", S_FALL, 340, 10, 0, 1, 0);

    // Bounce up to vy=4, fall to 476, then cross the bottom
    do_reset();
    serve();
    for (int b = 1; b <= 12; b++) begin
      bounce();
      if (b == 4) chk_all("bounce4", S_FALL, 340, 0, 4, 2, 0);
    end
    chk_all("bounce12", S_FALL, 340, 0, 12, 4, 0);
    ticks(119, 0, 0);
    chk_all("at476", S_FALL, 340, 476, 12, 4, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_all("bottom_hit", S_OVER, 340, 479, 12, 4, 1);
    step(0, 0, 0, 0, 0, 0);
    chk_all("miss_one_cycle", S_OVER, 340, 479, 12, 4, 0);
    step(1, 0, 0, 1, 0, 0);
    chk_all("over_hold", S_OVER, 340, 479, 12, 4, 0);
    step(1, 1, 1, 0, 0, 0);
    chk_all("over_start_paused", S_OVER, 340, 479, 12, 4, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_all("over_to_idle", S_IDLE, 340, 0, 12, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_all("restart_clears_score", S_FALL, 340, 0, 0, 1, 0);

    // Horizontal clamping
    do_reset();
    serve();
    ticks(100, 1, 0);
    chk_all("left_clamp", S_FALL, 84, 100, 0, 1, 0);
    ticks(200, 0, 1);
    chk_all("right_clamp", S_FALL, 596, 300, 0, 1, 0);
    ticks(1, 1, 1);
    chk_all("both_hold", S_FALL, 596, 301, 0, 1, 0);

    // Platform beats bottom on the same tick; then rise runs out on the frame counter
    do_reset();
    serve();
    ticks(478, 0, 0);
    chk_all("at478", S_FALL, 340, 478, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    chk_all("platform_priority", S_RISE, 340, 478, 1, 1, 0);
    ticks(23, 0, 0);
    chk_all("rise23", S_RISE, 340, 455, 1, 1, 0);
    ticks(1, 0, 0);
    chk_all("rise_done", S_FALL, 340, 454, 1, 1, 0);

    // Pause freezes everything, including a start request
    do_reset();
    serve();
    ticks(5, 0, 0);
    for (int i = 0; i < 20; i++) step(1, (i == 10) ? 1 : 0, 1, 1, 0, 0);
    chk_all("pause_freeze", S_FALL, 340, 5, 0, 1, 0);

    // Asynchronous reset in the middle of a rise
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk_all("pre_reset_rise", S_RISE, 340, 4, 1, 1, 0);
    #3;
    reset = 1'b0;
    #1;
    chk_all("async_reset", S_IDLE, 340, 0, 0, 1, 0);
    #2;
    reset = 1'b1;
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    chk_all("idle_after_reset", S_IDLE, 340, 0, 0, 1, 0);

    // Score saturation and vy cap
    do_reset();
    serve();
    for (int b = 0; b < 255; b++) bounce();
    chk_all("score255", S_FALL, 340, 0, 255, 8, 0);
    bounce();
    chk_all("score_sat", S_FALL, 340, 0, 255, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
